// File: rtl/servo_update_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_update_sched_if                                         |
// | Description : Requester/register-side bundle for servo_update_sched.        |
// |               req/req_data come from the control sources; ack, leer, dato,  |
// |               frame_start and pending go back to them and to reg_y.         |
// | Ports       : req[NREQ], req_data[NREQ*cant_bits], ack[NREQ], leer,         |
// |               dato[cant_bits], frame_start, pending                         |
// | Modports    : master = requesters / reg_y side, slave = scheduler side      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface servo_update_sched_if #(
  parameter int cant_bits = 20,
  parameter int NREQ      = 4
);
  logic [NREQ-1:0]           req;
  logic [NREQ*cant_bits-1:0] req_data;
  logic [NREQ-1:0]           ack;
  logic                      leer;
  logic [cant_bits-1:0]      dato;
  logic                      frame_start;
  logic                      pending;

  modport master (
    output req, req_data,
    input  ack, leer, dato, frame_start, pending
  );

  modport slave (
    input  req, req_data,
    output ack, leer, dato, frame_start, pending
  );
endinterface
`default_nettype wire

// File: rtl/servo_update_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_update_sched                                            |
// | Description : Round-robin arbiter for NREQ servo position requesters. The   |
// |               accepted value is held and written into reg_y (via leer/dato) |
// |               only at a PWM frame boundary, so pulses never glitch.         |
// | Ports       : clk, rst (sync, active-high), bus (servo_update_sched_if      |
// |               slave: req, req_data, ack, leer, dato, frame_start, pending)  |
// | Config      : SERVO_CLAMP_EN - when defined, captured values are saturated  |
// |               to [POS_MIN, POS_MAX]; otherwise captured raw.                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module servo_update_sched #(
  parameter int cant_bits    = 20,
  parameter int NREQ         = 4,
  parameter int FRAME_CYCLES = 1000000,
  parameter int POS_MIN      = 50000,
  parameter int POS_MAX      = 100000
) (
  input wire logic            clk,
  input wire logic            rst,
  servo_update_sched_if.slave bus
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [cant_bits-1:0] C_CNT_LAST = cant_bits'(FRAME_CYCLES - 1);
  localparam logic [cant_bits-1:0] C_POS_MIN  = cant_bits'(POS_MIN);
  localparam logic [cant_bits-1:0] C_POS_MAX  = cant_bits'(POS_MAX);
  localparam logic [GW-1:0]        C_LAST_RST = GW'(NREQ - 1);

`ifdef SERVO_CLAMP_EN
  localparam bit C_CLAMP_EN = 1'b1;
`else
  localparam bit C_CLAMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [cant_bits-1:0]  r_cnt;
  logic [cant_bits-1:0]  r_hold;
  logic [NREQ-1:0]       r_ack;
  logic [GW-1:0]         r_last_grant;
  logic                  r_leer;
  logic                  r_frame_start;
  logic                  r_pending;

  logic                  w_cnt_last;
  logic                  w_arb_ok;
  logic                  w_found;
  logic                  w_grant;
  logic [GW-1:0]         w_grant_idx;
  logic [NREQ-1:0]       w_grant_onehot;
  logic [cant_bits-1:0]  w_grant_data;
  int                    w_idx;

  // Saturation is folded away at elaboration when clamping is disabled.
  function automatic logic [cant_bits-1:0] f_capture(input logic [cant_bits-1:0] v);
    logic [cant_bits-1:0] r;
    r = v;
    if (C_CLAMP_EN) begin
      if (v < C_POS_MIN)
        r = C_POS_MIN;
      else if (v > C_POS_MAX)
        r = C_POS_MAX;
    end
    return r;
  endfunction

  assign w_cnt_last = (r_cnt == C_CNT_LAST);

  // No grant in the last frame cycle (hold must be stable going into commit)
  // nor while an ack is out (the acked requester still shows req this cycle).
  assign w_arb_ok = !w_cnt_last && (r_ack == '0);

  // Round-robin search starting one past the previous winner.
  always_comb begin
    w_found        = 1'b0;
    w_grant_idx    = '0;
    w_grant_onehot = '0;
    w_grant_data   = '0;
    w_idx          = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_last_grant) + k) % NREQ;
      if (!w_found && bus.req[w_idx]) begin
        w_found               = 1'b1;
        w_grant_idx           = GW'(w_idx);
        w_grant_onehot        = '0;
        w_grant_onehot[w_idx] = 1'b1;
        w_grant_data          = bus.req_data[w_idx*cant_bits +: cant_bits];
      end
    end
  end

  assign w_grant = w_found && w_arb_ok;

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant) begin
      // A grant in any state (including COMMIT) lands a value in HOLD.
      w_state_nxt = S_HOLD;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_IDLE;
        S_HOLD:   w_state_nxt = w_cnt_last ? S_COMMIT : S_HOLD;
        S_COMMIT: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_ack         <= '0;
      r_last_grant  <= C_LAST_RST;
      r_leer        <= 1'b0;
      r_frame_start <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_last ? '0 : r_cnt + 1'b1;
      r_frame_start <= w_cnt_last;
      // COMMIT is only entered from HOLD at the wrap, so leer lands on cnt==0.
      r_leer        <= (w_state_nxt == S_COMMIT);
      // Value stays outstanding until reg_y has sampled it at the end of COMMIT.
      r_pending     <= (w_state_nxt != S_IDLE);
      r_ack         <= w_grant ? w_grant_onehot : '0;
      if (w_grant) begin
        r_hold       <= f_capture(w_grant_data);
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign bus.ack         = r_ack;
  assign bus.leer        = r_leer;
  assign bus.dato        = r_hold;
  assign bus.frame_start = r_frame_start;
  assign bus.pending     = r_pending;

endmodule
`default_nettype wire
